avalon_msg_limiter: RTL
=======================

# avalon_msg_limiter

Downstream stage of the Avalon-ST SOP/EOP enforcer. It takes already-framed messages, counts payload bytes per message and caps every message at `MAX_MSG_BYTES`. An over-long message is truncated by forcing EOP at the limit and silently dropping the remaining beats. The output goes through a single registered pipeline stage and the block reports the length of each emitted message.

## Interface
- `DATA_WIDTH_IN_BYTES`, default 16: beat width in bytes (W). Data is W*8 bits; empty is `log2up_func(W)` bits.
- `MAX_MSG_BYTES`, default 1500: maximum emitted message length in bytes. Must satisfy `MAX_MSG_BYTES >= DATA_WIDTH_IN_BYTES`.
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `msg_in`, `avalon_st_if.slave`: input stream (valid, rdy, sop, eop, data, empty).
- `msg_out`, `avalon_st_if.master`: limited stream, registered.
- `truncated_indi`, output, 1: one-cycle pulse when a truncating beat is accepted.
- `msg_len`, output, `log2up_func(MAX_MSG_BYTES+1)` bits: byte length of the last emitted message, registered.
- `msg_len_valid`, output, 1: one-cycle pulse when `msg_len` updates.

## Operation
- Beat accepted when `msg_in.valid & msg_in.rdy`.
- Beat bytes: `W - msg_in.empty` if eop, else W.
- Empty bytes are the least-significant bytes. The output always zeroes bytes `[empty-1:0]`.
- Byte counter `cnt`, width `log2up_func(MAX_MSG_BYTES+W)`. Per beat: `cnt_new = cnt + beat_bytes`, or just `beat_bytes` on a sop beat in IDLE.
- States:
  - IDLE (between messages):
    - Accepted sop beat: emit it and go to PASS, unless the cap rule fires or the beat has eop.
    - Accepted non-sop beat: discard it, no indication.
  - PASS (inside a message):
    - Accepted beats are emitted.
    - Input eop: go to IDLE.
    - Any sop inside a message is treated as plain data.
  - DROP (truncated message tail):
    - `msg_in.rdy = 1` unconditionally; beats are discarded.
    - Accepted eop beat: go to IDLE. Nothing is emitted.
- Cap rule, checked on every emitted beat. It fires if `cnt_new > MAX` or (`cnt_new == MAX` and input eop = 0). When it fires:
  - Output eop = 1 and output empty = `W - (MAX - cnt)`; on a sop beat in IDLE, `cnt` counts as 0.
  - Data bytes below that empty are zeroed.
  - `truncated_indi` pulses.
  - Next state: DROP if input eop = 0, else IDLE.
- A message of exactly `MAX_MSG_BYTES` is never truncated.
- Single-beat message (sop & eop) in IDLE: emitted with its own empty, state stays IDLE.
- On every emitted eop beat:
  - `msg_len <= cnt_new`, capped at `MAX_MSG_BYTES`.
  - `msg_len_valid` pulses in the same cycle the output beat first becomes valid.
- Sop is passed through only on the first beat of a message. Empty is forced to 0 on non-eop output beats.

## Timing
- Latency: input beat accepted at edge N appears on `msg_out` after edge N, i.e. 1 cycle.
- Throughput: one beat per cycle when `msg_out.rdy = 1`.
- Ready: in IDLE/PASS, `msg_in.rdy = !out_valid_q | msg_out.rdy`. In DROP, `msg_in.rdy = 1`.
- Output register:
  - Loads on accept. Clears valid when `msg_out.rdy` is high and no new beat is loaded.
  - Data, sop, eop and empty are held stable while `valid & !rdy`.
- Simultaneous output pop and input accept: the register loads the new beat; no bubble.
- DROP with the output stalled: the held output beat (the truncating eop beat) stays stable while input beats drain.
- Reset (asynchronous assert, any cycle, including mid-message or in DROP):
  - State = IDLE, `cnt` = 0.
  - `msg_out` valid/sop/eop/data/empty = 0.
  - `truncated_indi` = 0, `msg_len` = 0, `msg_len_valid` = 0.
  - Any partial message is abandoned.
- After reset release, the first beat without sop is discarded.

## Test plan
Configuration: W = 16, MAX_MSG_BYTES = 60.
- **Short message.** 3 beats, last beat eop with empty = 4 -> emitted unchanged, 1 cycle later; `msg_len` = 44 with one `msg_len_valid` pulse; `truncated_indi` stays 0.
- **Exact limit.** 4 beats, last beat eop with empty = 4 (60 bytes) -> emitted unchanged; `msg_len` = 60; no truncation.
- **Over-long message.** 6 full beats, last eop with empty = 0, with `msg_out.rdy = 0` during beats 5-6 ->
  - Emits 4 beats; beat 4 has eop = 1, empty = 4, low 4 bytes zero.
  - `truncated_indi` pulses once; beats 5-6 are accepted with rdy = 1 and dropped.
  - `msg_len` = 60; next message passes normally.
- **Backpressure.** `msg_out.rdy` low for 3 cycles during beat 2 of a 3-beat message -> `msg_in.rdy` low, output beat held bit-stable, no beat lost or duplicated, output order preserved.
- **Reset mid-message.** Assert `rst` low after beat 2 of 4 -> all outputs 0 immediately. After release:
  - Stray non-sop beats are dropped.
  - A new 2-beat message (empty = 8) is emitted with `msg_len` = 24.
- **Back-to-back single-beat messages.** Sop & eop each cycle with empty 0, 5, 15 -> emitted on consecutive cycles; `msg_len` = 16, 11, 1.

Source files
------------

// File: rtl/avalon_msg_limiter_if.sv
// rtl/avalon_msg_limiter_if.sv - Avalon-ST style beat stream interface
interface avalon_msg_limiter_if #(
    parameter int DATA_WIDTH_IN_BYTES = 16
);
    localparam int EMPTY_W = (DATA_WIDTH_IN_BYTES <= 2) ? 1 : $clog2(DATA_WIDTH_IN_BYTES);

    logic                             valid;
    logic                             rdy;
    logic                             sop;
    logic                             eop;
    logic [DATA_WIDTH_IN_BYTES*8-1:0] data;
    logic [EMPTY_W-1:0]               empty;

    modport master (output valid, sop, eop, data, empty, input rdy);
    modport slave  (input valid, sop, eop, data, empty, output rdy);
endinterface

// File: rtl/avalon_msg_limiter.sv
// rtl/avalon_msg_limiter.sv - caps framed messages at MAX_MSG_BYTES and reports emitted lengths
module avalon_msg_limiter #(
    parameter int DATA_WIDTH_IN_BYTES = 16,
    parameter int MAX_MSG_BYTES       = 1500
) (
    input  logic                               clk,
    input  logic                               rst,
    avalon_msg_limiter_if.slave                msg_in,
    avalon_msg_limiter_if.master               msg_out,
    output logic                               truncated_indi,
    output logic [$clog2(MAX_MSG_BYTES+1)-1:0] msg_len,
    output logic                               msg_len_valid
);
    localparam int W       = DATA_WIDTH_IN_BYTES;
    localparam int EMPTY_W = (W <= 2) ? 1 : $clog2(W);
    localparam int CNT_W   = $clog2(MAX_MSG_BYTES + W);
    localparam int LEN_W   = $clog2(MAX_MSG_BYTES + 1);

    localparam logic [CNT_W-1:0] W_C   = CNT_W'(W);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_MSG_BYTES);

    typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               out_valid_q, out_sop_q, out_eop_q;
    logic [W*8-1:0]     out_data_q;
    logic [EMPTY_W-1:0] out_empty_q;
    logic               trunc_q, len_valid_q;
    logic [LEN_W-1:0]   len_q;

    logic               in_rdy, accept, emit, cap;
    logic [CNT_W-1:0]   base, beat_bytes, cnt_new;
    logic               nxt_sop, nxt_eop;
    logic [EMPTY_W-1:0] nxt_empty;
    logic [W*8-1:0]     nxt_data;
    logic [LEN_W-1:0]   nxt_len;

    // State and byte-count register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, cap decision and the beat to be loaded into the output stage
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        emit       = 1'b0;
        // In DROP the tail is drained regardless of output backpressure.
        in_rdy     = (state_q == DROP) | !out_valid_q | msg_out.rdy;
        accept     = msg_in.valid & in_rdy;
        // A sop beat in IDLE starts a fresh count.
        base       = (state_q == IDLE) ? '0 : cnt_q;
        beat_bytes = msg_in.eop ? (W_C - CNT_W'(msg_in.empty)) : W_C;
        cnt_new    = base + beat_bytes;
        // Hitting the cap exactly without eop still truncates: more bytes would follow.
        cap        = (cnt_new > MAX_C) | ((cnt_new == MAX_C) & !msg_in.eop);

        case (state_q)
            IDLE:    emit = accept & msg_in.sop;
            PASS:    emit = accept;
            DROP:    if (accept && msg_in.eop) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (emit) begin
            if (msg_in.eop)  state_d = IDLE;
            else if (cap)    state_d = DROP;
            else             state_d = PASS;
            cnt_d = (state_d == PASS) ? cnt_new : '0;
        end

        nxt_sop = (state_q == IDLE);
        nxt_eop = msg_in.eop | cap;
        if (cap)             nxt_empty = EMPTY_W'(W_C - (MAX_C - base));
        else if (msg_in.eop) nxt_empty = msg_in.empty;
        else                 nxt_empty = '0;

        // Bytes below empty are the unused least-significant bytes.
        nxt_data = msg_in.data;
        for (int i = 0; i < W; i++) begin
            if (i < int'(nxt_empty)) nxt_data[i*8 +: 8] = 8'h00;
        end

        nxt_len = cap ? LEN_W'(MAX_MSG_BYTES) : LEN_W'(cnt_new);
    end

    // Registered output stage plus truncation and length reporting
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_data_q  <= '0;
            out_empty_q <= '0;
            trunc_q     <= 1'b0;
            len_q       <= '0;
            len_valid_q <= 1'b0;
        end else begin
            trunc_q     <= emit & cap;
            len_valid_q <= emit & nxt_eop;
            if (emit) begin
                out_valid_q <= 1'b1;
                out_sop_q   <= nxt_sop;
                out_eop_q   <= nxt_eop;
                out_data_q  <= nxt_data;
                out_empty_q <= nxt_empty;
                if (nxt_eop) len_q <= nxt_len;
            end else if (msg_out.rdy) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign msg_in.rdy     = in_rdy;
    assign msg_out.valid  = out_valid_q;
    assign msg_out.sop    = out_sop_q;
    assign msg_out.eop    = out_eop_q;
    assign msg_out.data   = out_data_q;
    assign msg_out.empty  = out_empty_q;
    assign truncated_indi = trunc_q;
    assign msg_len        = len_q;
    assign msg_len_valid  = len_valid_q;
endmodule
